// File: rtl/blob_tracker.sv
// blob_tracker: streaming connected-region tracker for binarised video lines.
// Scans each accepted line one pixel per cycle, folds horizontal runs into a
// small set of region slots, then sorts the slots by pixel count at frame end.
module blob_tracker #(
    parameter int unsigned IMG_W    = 320,
    parameter int unsigned IMG_H    = 240,
    parameter int unsigned N_BLOBS  = 3,
    parameter int unsigned MERGE_DX = 4,
    parameter int unsigned MERGE_DY = 2,
    parameter int unsigned CNT_W    = 17,
    localparam int unsigned X_W = $clog2(IMG_W),
    localparam int unsigned Y_W = $clog2(IMG_H)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_start,
    input  logic [IMG_W-1:0]               line_data,
    input  logic                           line_valid,
    output logic                           line_ready,
    output logic [N_BLOBS*CNT_W-1:0]       blob_cnt,
    output logic [N_BLOBS*(X_W+Y_W)-1:0]   blob_xy,
    output logic [N_BLOBS-1:0]             blob_valid,
    output logic                           frame_done,
    output logic                           overflow
);

    localparam int unsigned XY_W = X_W + Y_W;
    localparam int unsigned IX_W = $clog2(IMG_W + 2);
    localparam int unsigned XC_W = $clog2(IMG_W + MERGE_DX + 1) + 1;
    localparam int unsigned YC_W = $clog2(IMG_H + MERGE_DY + 1) + 1;
    localparam int unsigned SL_W = (N_BLOBS > 1) ? $clog2(N_BLOBS) : 1;
    localparam logic [X_W-1:0]  COL_LAST   = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]  ROW_LAST   = Y_W'(IMG_H - 1);
    localparam logic [SL_W-1:0] STAGE_LAST = SL_W'(N_BLOBS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_SCAN, S_MERGE, S_NEXT, S_SORT, S_DONE
    } state_t;

    state_t             state;
    logic [IMG_W-1:0]   pix;
    logic [Y_W-1:0]     row;
    logic [X_W-1:0]     col;
    logic [X_W-1:0]     rs;
    logic [SL_W-1:0]    stage;

    // region slots
    logic [N_BLOBS-1:0] sv;
    logic [X_W-1:0]     sx_min [N_BLOBS];
    logic [X_W-1:0]     sx_max [N_BLOBS];
    logic [Y_W-1:0]     sy_min [N_BLOBS];
    logic [Y_W-1:0]     sy_max [N_BLOBS];
    logic [CNT_W-1:0]   s_cnt  [N_BLOBS];

    // sort network registers and one-stage result
    logic [CNT_W-1:0]   q_cnt   [N_BLOBS];
    logic [XY_W-1:0]    q_xy    [N_BLOBS];
    logic [N_BLOBS-1:0] q_v;
    logic [CNT_W-1:0]   q_cnt_n [N_BLOBS];
    logic [XY_W-1:0]    q_xy_n  [N_BLOBS];
    logic [N_BLOBS-1:0] q_v_n;

    logic [IMG_W+1:0]   pix_ext;
    logic [IX_W-1:0]    pidx;
    logic               cur_pix;
    logic               run_start_c;
    logic               run_end_c;
    logic               hit_c;
    logic               free_c;
    logic [SL_W-1:0]    hit_idx_c;
    logic [SL_W-1:0]    free_idx_c;
    logic [X_W:0]       len_c;
    logic [CNT_W-1:0]   base_c;
    logic [CNT_W:0]     sum_c;
    logic [CNT_W-1:0]   cnt_new_c;
    logic [X_W:0]       xsum_c [N_BLOBS];
    logic [Y_W:0]       ysum_c [N_BLOBS];
    logic [XY_W-1:0]    centre_c [N_BLOBS];

    // Pixel neighbourhood at the scan column; neighbours off the line read as 0
    always_comb begin
        pix_ext     = {1'b0, pix, 1'b0};
        pidx        = IX_W'(col);
        cur_pix     = pix_ext[pidx + IX_W'(1)];
        run_start_c = cur_pix & ~pix_ext[pidx];
        run_end_c   = cur_pix & ~pix_ext[pidx + IX_W'(2)];
    end

    // Slot match / free-slot search for run [rs, col] and its saturated count
    always_comb begin
        hit_c      = 1'b0;
        free_c     = 1'b0;
        hit_idx_c  = '0;
        free_idx_c = '0;
        for (int k = int'(N_BLOBS) - 1; k >= 0; k--) begin
            if (sv[k]
                && (XC_W'(rs) <= XC_W'(sx_max[k]) + XC_W'(MERGE_DX))
                && (XC_W'(col) + XC_W'(MERGE_DX) >= XC_W'(sx_min[k]))
                && (YC_W'(row) <= YC_W'(sy_max[k]) + YC_W'(MERGE_DY))) begin
                hit_c     = 1'b1;
                hit_idx_c = SL_W'(k);
            end
            if (!sv[k]) begin
                free_c     = 1'b1;
                free_idx_c = SL_W'(k);
            end
        end
        len_c     = {1'b0, col} - {1'b0, rs} + (X_W+1)'(1);
        base_c    = hit_c ? s_cnt[hit_idx_c] : '0;
        sum_c     = {1'b0, base_c} + (CNT_W+1)'(len_c);
        cnt_new_c = sum_c[CNT_W] ? '1 : sum_c[CNT_W-1:0];
    end

    // Bounding-box centres, sums kept one bit wider so the carry survives
    always_comb begin
        for (int k = 0; k < int'(N_BLOBS); k++) begin
            xsum_c[k]   = {1'b0, sx_min[k]} + {1'b0, sx_max[k]};
            ysum_c[k]   = {1'b0, sy_min[k]} + {1'b0, sy_max[k]};
            centre_c[k] = {X_W'(xsum_c[k] >> 1), Y_W'(ysum_c[k] >> 1)};
        end
    end

    // One odd-even transposition stage; strict compare keeps equal counts in order
    always_comb begin
        q_cnt_n = q_cnt;
        q_xy_n  = q_xy;
        q_v_n   = q_v;
        for (int j = 0; j < int'(N_BLOBS) - 1; j++) begin
            if ((j[0] == stage[0]) && (q_cnt[j+1] > q_cnt[j])) begin
                q_cnt_n[j]   = q_cnt[j+1];
                q_cnt_n[j+1] = q_cnt[j];
                q_xy_n[j]    = q_xy[j+1];
                q_xy_n[j+1]  = q_xy[j];
                q_v_n[j]     = q_v[j+1];
                q_v_n[j+1]   = q_v[j];
            end
        end
    end

    // Frame FSM with slot updates and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pix        <= '0;
            row        <= '0;
            col        <= '0;
            rs         <= '0;
            stage      <= '0;
            sv         <= '0;
            q_v        <= '0;
            line_ready <= 1'b0;
            blob_cnt   <= '0;
            blob_xy    <= '0;
            blob_valid <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            for (int k = 0; k < int'(N_BLOBS); k++) begin
                sx_min[k] <= '0;
                sx_max[k] <= '0;
                sy_min[k] <= '0;
                sy_max[k] <= '0;
                s_cnt[k]  <= '0;
                q_cnt[k]  <= '0;
                q_xy[k]   <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            line_ready <= 1'b0;
            if (frame_start) begin
                state      <= S_WAIT;
                line_ready <= 1'b1;
                row        <= '0;
                col        <= '0;
                sv         <= '0;
                overflow   <= 1'b0;
                for (int k = 0; k < int'(N_BLOBS); k++) begin
                    sx_min[k] <= '0;
                    sx_max[k] <= '0;
                    sy_min[k] <= '0;
                    sy_max[k] <= '0;
                    s_cnt[k]  <= '0;
                end
            end else begin
                case (state)
                    S_IDLE: ;
                    S_WAIT: begin
                        if (line_valid && line_ready) begin
                            pix   <= line_data;
                            col   <= '0;
                            state <= S_SCAN;
                        end else begin
                            line_ready <= 1'b1;
                        end
                    end
                    S_SCAN: begin
                        if (run_start_c) rs <= col;
                        if (run_end_c) begin
                            state <= S_MERGE;
                        end else if (col == COL_LAST) begin
                            state <= S_NEXT;
                        end else begin
                            col <= col + X_W'(1);
                        end
                    end
                    S_MERGE: begin
                        if (hit_c) begin
                            if (rs < sx_min[hit_idx_c]) sx_min[hit_idx_c] <= rs;
                            if (col > sx_max[hit_idx_c]) sx_max[hit_idx_c] <= col;
                            sy_max[hit_idx_c] <= row;
                            s_cnt[hit_idx_c]  <= cnt_new_c;
                        end else if (free_c) begin
                            sv[free_idx_c]     <= 1'b1;
                            sx_min[free_idx_c] <= rs;
                            sx_max[free_idx_c] <= col;
                            sy_min[free_idx_c] <= row;
                            sy_max[free_idx_c] <= row;
                            s_cnt[free_idx_c]  <= cnt_new_c;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (col == COL_LAST) begin
                            state <= S_NEXT;
                        end else begin
                            col   <= col + X_W'(1);
                            state <= S_SCAN;
                        end
                    end
                    S_NEXT: begin
                        if (row == ROW_LAST) begin
                            for (int k = 0; k < int'(N_BLOBS); k++) begin
                                q_cnt[k] <= sv[k] ? s_cnt[k] : '0;
                                q_xy[k]  <= sv[k] ? centre_c[k] : '0;
                            end
                            q_v   <= sv;
                            stage <= '0;
                            state <= S_SORT;
                        end else begin
                            row        <= row + Y_W'(1);
                            state      <= S_WAIT;
                            line_ready <= 1'b1;
                        end
                    end
                    S_SORT: begin
                        q_cnt <= q_cnt_n;
                        q_xy  <= q_xy_n;
                        q_v   <= q_v_n;
                        if (stage == STAGE_LAST) begin
                            state <= S_DONE;
                        end else begin
                            stage <= stage + SL_W'(1);
                        end
                    end
                    S_DONE: begin
                        for (int k = 0; k < int'(N_BLOBS); k++) begin
                            blob_cnt[k*CNT_W +: CNT_W] <= q_cnt[k];
                            blob_xy[k*XY_W +: XY_W]    <= q_xy[k];
                        end
                        blob_valid <= q_v;
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blob_tracker.sv
// tb_blob_tracker: directed and random frames against a behavioural region model.
module tb_blob_tracker;

    localparam int unsigned IMG_W    = 64;
    localparam int unsigned IMG_H    = 32;
    localparam int unsigned N_BLOBS  = 3;
    localparam int unsigned MERGE_DX = 4;
    localparam int unsigned MERGE_DY = 2;
    localparam int unsigned CNT_W    = 10;
    localparam int unsigned X_W      = $clog2(IMG_W);
    localparam int unsigned Y_W      = $clog2(IMG_H);
    localparam int unsigned XY_W     = X_W + Y_W;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic                         clk;
    logic                         rst_n;
    logic                         frame_start;
    logic [IMG_W-1:0]             line_data;
    logic                         line_valid;
    logic                         line_ready;
    logic [N_BLOBS*CNT_W-1:0]     blob_cnt;
    logic [N_BLOBS*XY_W-1:0]      blob_xy;
    logic [N_BLOBS-1:0]           blob_valid;
    logic                         frame_done;
    logic                         overflow;

    blob_tracker #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .N_BLOBS(N_BLOBS),
        .MERGE_DX(MERGE_DX), .MERGE_DY(MERGE_DY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .line_data(line_data), .line_valid(line_valid), .line_ready(line_ready),
        .blob_cnt(blob_cnt), .blob_xy(blob_xy), .blob_valid(blob_valid),
        .frame_done(frame_done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [IMG_W-1:0]   frame [IMG_H];
    int                 exp_cnt [N_BLOBS];
    int                 exp_x   [N_BLOBS];
    int                 exp_y   [N_BLOBS];
    logic [N_BLOBS-1:0] exp_v;
    logic               exp_ovf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] cnt_at(input int k);
        return blob_cnt[k*CNT_W +: CNT_W];
    endfunction

    function automatic logic [XY_W-1:0] xy_at(input int k);
        return blob_xy[k*XY_W +: XY_W];
    endfunction

    function automatic logic [63:0] xy_of(input int x, input int y);
        logic [XY_W-1:0] v;
        v = {X_W'(x), Y_W'(y)};
        return 64'(v);
    endfunction

    task automatic clear_frame();
        for (int r = 0; r < int'(IMG_H); r++) frame[r] = '0;
    endtask

    task automatic rect(input int x0, input int x1, input int y0, input int y1);
        for (int r = y0; r <= y1; r++)
            for (int c = x0; c <= x1; c++) frame[r][c] = 1'b1;
    endtask

    // Region model: runs found per row, merged into the lowest matching slot,
    // then a stable descending sort by count (empty slots count as 0).
    task automatic model_frame();
        int vld [N_BLOBS];
        int xmn [N_BLOBS];
        int xmx [N_BLOBS];
        int ymn [N_BLOBS];
        int ymx [N_BLOBS];
        int cn  [N_BLOBS];
        int key [N_BLOBS];
        int idx [$];
        exp_ovf = 1'b0;
        for (int k = 0; k < int'(N_BLOBS); k++) begin
            vld[k] = 0; xmn[k] = 0; xmx[k] = 0; ymn[k] = 0; ymx[k] = 0; cn[k] = 0;
        end
        for (int r = 0; r < int'(IMG_H); r++) begin
            int c;
            c = 0;
            while (c < int'(IMG_W)) begin
                if (frame[r][c]) begin
                    int s, e, hit, fr;
                    s = c;
                    while (c + 1 < int'(IMG_W) && frame[r][c+1]) c++;
                    e = c;
                    hit = -1;
                    fr  = -1;
                    for (int k = int'(N_BLOBS) - 1; k >= 0; k--) begin
                        if (vld[k] != 0 && s <= xmx[k] + int'(MERGE_DX) &&
                            e + int'(MERGE_DX) >= xmn[k] && r <= ymx[k] + int'(MERGE_DY))
                            hit = k;
                        if (vld[k] == 0) fr = k;
                    end
                    if (hit >= 0) begin
                        if (s < xmn[hit]) xmn[hit] = s;
                        if (e > xmx[hit]) xmx[hit] = e;
                        ymx[hit] = r;
                        cn[hit]  = cn[hit] + (e - s + 1);
                        if (cn[hit] > CNT_MAX) cn[hit] = CNT_MAX;
                    end else if (fr >= 0) begin
                        vld[fr] = 1; xmn[fr] = s; xmx[fr] = e; ymn[fr] = r; ymx[fr] = r;
                        cn[fr]  = (e - s + 1 > CNT_MAX) ? CNT_MAX : e - s + 1;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
                c++;
            end
        end
        for (int k = 0; k < int'(N_BLOBS); k++) begin
            key[k] = (vld[k] != 0) ? cn[k] : 0;
            idx.push_back(k);
        end
        for (int p = 0; p < int'(N_BLOBS); p++) begin
            int b, s;
            b = 0;
            for (int i = 1; i < idx.size(); i++)
                if (key[idx[i]] > key[idx[b]]) b = i;
            s = idx[b];
            idx.delete(b);
            exp_cnt[p] = key[s];
            exp_v[p]   = (vld[s] != 0);
            exp_x[p]   = (vld[s] != 0) ? (xmn[s] + xmx[s]) / 2 : 0;
            exp_y[p]   = (vld[s] != 0) ? (ymn[s] + ymx[s]) / 2 : 0;
        end
    endtask

    task automatic check_out(input string tag);
        for (int k = 0; k < int'(N_BLOBS); k++) begin
            chk($sformatf("%s.cnt%0d", tag, k), 64'(cnt_at(k)), 64'(exp_cnt[k]));
            chk($sformatf("%s.xy%0d", tag, k), 64'(xy_at(k)), xy_of(exp_x[k], exp_y[k]));
        end
        chk($sformatf("%s.valid", tag), 64'(blob_valid), 64'(exp_v));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".cnt"}, 64'(blob_cnt), 64'd0);
        chk({tag, ".xy"}, 64'(blob_xy), 64'd0);
        chk({tag, ".valid"}, 64'(blob_valid), 64'd0);
        chk({tag, ".done"}, 64'(frame_done), 64'd0);
        chk({tag, ".ovf"}, 64'(overflow), 64'd0);
        chk({tag, ".ready"}, 64'(line_ready), 64'd0);
    endtask

    task automatic start_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!line_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!line_ready) chk("ready_timeout", 64'(line_ready), 64'd1);
    endtask

    task automatic send_lines(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            wait_ready();
            line_valid = 1'b1;
            line_data  = frame[r];
            @(negedge clk);
            line_valid = 1'b0;
            line_data  = {$urandom, $urandom};
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!frame_done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) chk("done_timeout", 64'(frame_done), 64'd1);
    endtask

    task automatic check_result(input string tag);
        model_frame();
        check_out(tag);
        chk({tag, ".ovf"}, 64'(overflow), 64'(exp_ovf));
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(frame_done), 64'd0);
    endtask

    task automatic run_frame(input string tag);
        start_frame();
        send_lines(0, int'(IMG_H) - 1);
        wait_done();
        check_result(tag);
    endtask

    task automatic rand_rects();
        int n, x0, y0;
        clear_frame();
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
            x0 = $urandom_range(0, IMG_W - 1);
            y0 = $urandom_range(0, IMG_H - 1);
            rect(x0, (x0 + int'($urandom_range(0, 11)) > int'(IMG_W) - 1) ? int'(IMG_W) - 1 : x0 + int'($urandom_range(0, 11)),
                 y0, (y0 + 6 > int'(IMG_H) - 1) ? int'(IMG_H) - 1 : y0 + int'($urandom_range(0, 6)));
        end
    endtask

    task automatic rand_noise();
        for (int r = 0; r < int'(IMG_H); r++)
            frame[r] = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
    endtask

    initial begin
        int r, n;
        logic rdy;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        line_valid  = 1'b0;
        line_data   = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 64'(line_ready), 64'd0);

        clear_frame();
        run_frame("empty");
        chk("empty.valid_c", 64'(blob_valid), 64'd0);

        clear_frame();
        rect(10, 19, 5, 14);
        run_frame("rect");
        chk("rect.cnt_c", 64'(cnt_at(0)), 64'd100);
        chk("rect.xy_c", 64'(xy_at(0)), xy_of(14, 9));
        chk("rect.valid_c", 64'(blob_valid), 64'b001);

        clear_frame();
        rect(40, 49, 0, 9);
        rect(0, 19, 2, 21);
        rect(40, 54, 15, 29);
        run_frame("three");
        chk("three.cnt0_c", 64'(cnt_at(0)), 64'd400);
        chk("three.cnt1_c", 64'(cnt_at(1)), 64'd225);
        chk("three.cnt2_c", 64'(cnt_at(2)), 64'd100);
        chk("three.xy0_c", 64'(xy_at(0)), xy_of(9, 11));
        chk("three.xy1_c", 64'(xy_at(1)), xy_of(47, 22));
        chk("three.xy2_c", 64'(xy_at(2)), xy_of(44, 4));

        clear_frame();
        rect(0, 4, 0, 4);
        rect(12, 16, 0, 4);
        rect(24, 28, 0, 4);
        rect(48, 52, 10, 14);
        run_frame("ovf");
        chk("ovf.flag_c", 64'(overflow), 64'd1);
        chk("ovf.valid_c", 64'(blob_valid), 64'b111);
        chk("ovf.xy2_c", 64'(xy_at(2)), xy_of(26, 2));

        // abort mid-frame: outputs hold, overflow clears, frame_start beats a transfer
        rand_rects();
        start_frame();
        send_lines(0, 9);
        start_frame();
        check_out("abort_hold");
        chk("abort.ovf_clear", 64'(overflow), 64'd0);
        wait_ready();
        frame_start = 1'b1;
        line_valid  = 1'b1;
        line_data   = '1;
        @(negedge clk);
        frame_start = 1'b0;
        line_valid  = 1'b0;
        chk("fs_wins.ready", 64'(line_ready), 64'd1);
        rand_noise();
        send_lines(0, int'(IMG_H) - 1);
        wait_done();
        check_result("abort_new");

        clear_frame();
        for (int i = 0; i < int'(IMG_H); i++) begin
            frame[i][0]         = 1'b1;
            frame[i][IMG_W - 1] = 1'b1;
        end
        run_frame("edge");
        chk("edge.cnt0_c", 64'(cnt_at(0)), 64'd32);
        chk("edge.xy0_c", 64'(xy_at(0)), xy_of(0, 15));
        chk("edge.xy1_c", 64'(xy_at(1)), xy_of(63, 15));
        chk("edge.valid_c", 64'(blob_valid), 64'b011);

        for (int i = 0; i < int'(IMG_H); i++) frame[i] = '1;
        run_frame("sat");
        chk("sat.cnt0_c", 64'(cnt_at(0)), 64'(CNT_MAX));
        chk("sat.xy0_c", 64'(xy_at(0)), xy_of(31, 15));

        // line_valid held high; garbage presented whenever ready is low
        rand_rects();
        start_frame();
        line_valid = 1'b1;
        r = 0;
        n = 0;
        while (r < int'(IMG_H) && n < 20000) begin
            if (line_ready) line_data = frame[r];
            else            line_data = {$urandom, $urandom};
            rdy = line_ready;
            @(negedge clk);
            n++;
            if (rdy) r++;
        end
        line_valid = 1'b0;
        if (r < int'(IMG_H)) chk("held.lines", 64'(r), 64'(IMG_H));
        wait_done();
        check_result("held");

        // asynchronous reset while a line is being scanned
        start_frame();
        send_lines(0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("rst_scan");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_scan.idle", 64'(line_ready), 64'd0);

        for (int i = 0; i < 3; i++) begin
            rand_noise();
            run_frame($sformatf("noise%0d", i));
            rand_rects();
            run_frame($sformatf("rects%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
